eth_mdio_ctrl: RTL and testbench
================================

// Module: eth_mdio_ctrl
// PURPOSE
//  MDIO (IEEE 802.3 clause 22) management master for the board Ethernet PHY (RMII).
//  Serialises one register read or write per command onto MDC/MDIO and returns read data.
//  Sits beside eth_rst_gen in the top level; clk/rst are the system clock and the rst_gen output.
//  Lets the design configure and poll the PHY once the PHY is out of reset.
// PARAMETERS
//  CLK_DIV   20    clk cycles per MDC half-period (100 MHz -> 2.5 MHz MDC); legal >= 2
//  PHY_ADDR  5'd1  PHYAD field sent in every frame
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous, active-high reset
//  cmd_valid   in   1   command request
//  cmd_ready   out  1   block can accept a command (high only in IDLE)
//  cmd_write   in   1   1 = write, 0 = read
//  cmd_reg     in   5   REGAD field
//  cmd_wdata   in   16  write data (ignored for reads)
//  rsp_valid   out  1   one-cycle pulse: frame complete
//  rsp_rdata   out  16  read data; 16'h0000 after a write
//  rsp_err     out  1   read turnaround bit 2 sampled 1 (no PHY answered)
//  busy        out  1   ~cmd_ready
//  mdc         out  1   management clock to the PHY
//  mdio_o      out  1   MDIO output value (to top-level IOBUF)
//  mdio_oe     out  1   MDIO output enable; 0 = released, pulled up
//  mdio_i      in   1   MDIO pin input
// BEHAVIOUR
//  Reset: cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mdc=0, mdio_o=1, mdio_oe=0.
//  Handshake: command accepted on a cycle with cmd_valid & cmd_ready; fields registered then;
//   cmd_ready drops the next cycle; no queueing; cmd_valid while busy is ignored, not lost to the master.
//  Bit slot = 2*CLK_DIV cycles: mdc low CLK_DIV cycles, then high CLK_DIV cycles; 50% duty.
//   mdio_o/mdio_oe change only on the first cycle of a slot (mdc low phase start).
//   mdio_i sampled on the last cycle of the low phase (cycle before mdc rises).
//  Frame, MSB first, 64 slots: PRE 32x'1' | ST 01 | OP 01 wr / 10 rd | PHYAD 5 | REGAD 5 | TA 2 | DATA 16.
//   Write: oe=1 for all 64 slots, TA driven 1,0, DATA = cmd_wdata.
//   Read: oe=1 through REGAD; oe=0 for TA and DATA; TA bit 2 sample -> rsp_err; DATA samples shift into rdata.
//  After the 64th slot one idle slot (oe=0, mdc low, mdio_o=1), then IDLE.
//  FSM: IDLE -> PRE(32) -> HDR(14) -> TA(2) -> DATA(16) -> DONE(1 slot) -> IDLE; per-state bit counter.
//  Latency: rsp_valid pulses exactly 65*2*CLK_DIV cycles after the accept cycle (2600 at default);
//   cmd_ready rises in the same cycle as rsp_valid; a held cmd_valid is accepted in that cycle.
//  rsp_rdata/rsp_err update with rsp_valid and hold until the next rsp_valid.
//  Read with rsp_err=1 still completes the full frame; rdata is whatever was sampled (16'hFFFF if released).
//  rst mid-frame: next cycle all outputs at reset values, no rsp_valid, partial frame abandoned.
// STRUCTURE
//  Package eth_mdio_pkg: state enum (IDLE,PRE,HDR,TA,DATA,DONE), MDIO_ST=2'b01, MDIO_OP_WR=2'b01,
//   MDIO_OP_RD=2'b10, PRE_BITS=32, FRAME_BITS=64.
//  Sub-module mdio_clk_div: counter producing mdc plus one-cycle slot_start / sample_en strobes;
//   held in reset (mdc=0, counter=0) while the FSM is in IDLE.
//  Top-level IOBUF for MDIO stays outside this block.
// TESTING
//  Write reg 0 = 16'h3100 -> PHY model decodes 32x1,01,01,00001,00000,10,3100; oe=1 in all 64 slots; rsp_rdata=0.
//  Read reg 1, model drives 0 then 16'h786D -> rsp_rdata=16'h786D, rsp_err=0, rsp_valid at cycle 2600.
//  Read reg 2, no PHY (mdio_i=1) -> rsp_err=1, rsp_rdata=16'hFFFF; oe=0 during all TA/DATA slots.
//  cmd_valid held for two commands -> 2nd accepted in the rsp_valid cycle; no idle gap beyond DONE slot.
//  rst asserted at slot 40 -> next cycle mdc=0, oe=0, cmd_ready=1; no rsp_valid; new command runs clean.
//  MDC check at CLK_DIV=20 and CLK_DIV=2: period 2*CLK_DIV, 50% duty; mdio_o changes only on mdc-low start.

Source files
------------

// File: rtl/eth_mdio_pkg.sv
// rtl/eth_mdio_pkg.sv - shared constants, state codes and frame helper for the MDIO master
package eth_mdio_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_PRE  = 3'd1;
    localparam state_t S_HDR  = 3'd2;
    localparam state_t S_TA   = 3'd3;
    localparam state_t S_DATA = 3'd4;
    localparam state_t S_DONE = 3'd5;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam int         PRE_BITS   = 32;
    localparam int         FRAME_BITS = 64;

    // Everything after the preamble, MSB first; reads carry 1s where the line is released.
    function automatic logic [31:0] mdio_tx_word(input logic write, input logic [4:0] phy,
                                                 input logic [4:0] regad, input logic [15:0] wdata);
        if (write)
            mdio_tx_word = {MDIO_ST, MDIO_OP_WR, phy, regad, 2'b10, wdata};
        else
            mdio_tx_word = {MDIO_ST, MDIO_OP_RD, phy, regad, 2'b11, 16'hFFFF};
    endfunction

endpackage

// File: rtl/eth_mdio_ctrl_if.sv
// rtl/eth_mdio_ctrl_if.sv - command/response bundle between a PHY manager and the MDIO master
interface eth_mdio_ctrl_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_reg;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_write, cmd_reg, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_reg, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mdio_clk_div.sv
// rtl/mdio_clk_div.sv - MDC generator with per-slot sample/end strobes, cleared while not running
module mdio_clk_div #(
    parameter int CLK_DIV = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic mdc,
    output logic sample_en,
    output logic slot_end,
    output logic slot_tail
);

    localparam int SLOT = 2 * CLK_DIV;
    localparam int CW   = $clog2(SLOT);

    localparam logic [CW-1:0] HALF = CW'(CLK_DIV);
    localparam logic [CW-1:0] SAMP = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] TAIL = CW'(SLOT - 2);
    localparam logic [CW-1:0] LAST = CW'(SLOT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !run)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign mdc       = run && (cnt >= HALF);
    assign sample_en = run && (cnt == SAMP);
    assign slot_tail = run && (cnt == TAIL);
    assign slot_end  = run && (cnt == LAST);

endmodule

// File: rtl/eth_mdio_ctrl.sv
// rtl/eth_mdio_ctrl.sv - clause 22 MDIO master: one register read or write per accepted command
import eth_mdio_pkg::*;

module eth_mdio_ctrl #(
    parameter int         CLK_DIV  = 20,
    parameter logic [4:0] PHY_ADDR = 5'd1
) (
    input  logic           clk,
    input  logic           rst,
    eth_mdio_ctrl_if.slave bus,
    output logic           busy,
    output logic           mdc,
    output logic           mdio_o,
    output logic           mdio_oe,
    input  logic           mdio_i
);

    state_t      state;
    logic [4:0]  bit_cnt;
    logic        is_write;
    logic [31:0] tx_sr;
    logic [15:0] rd_sr;
    logic        ta_err;
    logic        div_mdc;
    logic        sample_en;
    logic        slot_end;
    logic        slot_tail;
    logic        shifting;

    mdio_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk       (clk),
        .rst       (rst),
        .run       (state != S_IDLE),
        .mdc       (div_mdc),
        .sample_en (sample_en),
        .slot_end  (slot_end),
        .slot_tail (slot_tail)
    );

    assign bus.cmd_ready = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign shifting      = (state == S_HDR) || (state == S_TA) || (state == S_DATA);

    // The DONE slot keeps MDC low so the PHY sees a clean idle bit.
    assign mdc     = div_mdc && (state != S_DONE);
    assign mdio_o  = shifting ? tx_sr[31] : 1'b1;
    assign mdio_oe = (state == S_PRE) || (state == S_HDR) ||
                     (is_write && ((state == S_TA) || (state == S_DATA)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            bit_cnt       <= '0;
            is_write      <= 1'b0;
            tx_sr         <= '0;
            rd_sr         <= '0;
            ta_err        <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            if (shifting && slot_end)
                tx_sr <= {tx_sr[30:0], 1'b1};
            case (state)
                S_IDLE: if (bus.cmd_valid) begin
                    state    <= S_PRE;
                    bit_cnt  <= '0;
                    is_write <= bus.cmd_write;
                    tx_sr    <= mdio_tx_word(bus.cmd_write, PHY_ADDR, bus.cmd_reg, bus.cmd_wdata);
                end
                S_PRE: if (slot_end) begin
                    if (bit_cnt == 5'(PRE_BITS - 1)) begin
                        state   <= S_HDR;
                        bit_cnt <= '0;
                    end else
                        bit_cnt <= bit_cnt + 5'd1;
                end
                S_HDR: if (slot_end) begin
                    if (bit_cnt == 5'd13) begin
                        state   <= S_TA;
                        bit_cnt <= '0;
                    end else
                        bit_cnt <= bit_cnt + 5'd1;
                end
                S_TA: begin
                    // A PHY pulls the second turnaround bit low; a released line means nobody answered.
                    if (sample_en && bit_cnt == 5'd1)
                        ta_err <= mdio_i;
                    if (slot_end) begin
                        if (bit_cnt == 5'd1) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end else
                            bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                S_DATA: begin
                    if (sample_en)
                        rd_sr <= {rd_sr[14:0], mdio_i};
                    if (slot_end) begin
                        if (bit_cnt == 5'd15) begin
                            state   <= S_DONE;
                            bit_cnt <= '0;
                        end else
                            bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                S_DONE: if (slot_tail) begin
                    // Leaving one cycle early puts rsp_valid and cmd_ready on the slot's last cycle.
                    state         <= S_IDLE;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_rdata <= is_write ? 16'h0000 : rd_sr;
                    bus.rsp_err   <= !is_write && ta_err;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_mdio_ctrl.sv
// tb/tb_eth_mdio_ctrl.sv - self-checking bench for eth_mdio_ctrl at CLK_DIV 20 and 2
module tb_eth_mdio_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    eth_mdio_ctrl_if if0 ();
    eth_mdio_ctrl_if if1 ();

    logic        sel;
    logic        cv, cw;
    logic [4:0]  creg;
    logic [15:0] cwd;
    logic        mdio_i;
    logic        busy0, busy1, mdc0, mdc1, o0, o1, oe0, oe1;

    assign if0.cmd_valid = cv & ~sel;
    assign if1.cmd_valid = cv & sel;
    assign if0.cmd_write = cw;
    assign if1.cmd_write = cw;
    assign if0.cmd_reg   = creg;
    assign if1.cmd_reg   = creg;
    assign if0.cmd_wdata = cwd;
    assign if1.cmd_wdata = cwd;

    eth_mdio_ctrl #(.CLK_DIV(20), .PHY_ADDR(5'd1)) u_dut0 (
        .clk(clk), .rst(rst), .bus(if0), .busy(busy0), .mdc(mdc0),
        .mdio_o(o0), .mdio_oe(oe0), .mdio_i(mdio_i)
    );

    eth_mdio_ctrl #(.CLK_DIV(2), .PHY_ADDR(5'd1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(if1), .busy(busy1), .mdc(mdc1),
        .mdio_o(o1), .mdio_oe(oe1), .mdio_i(mdio_i)
    );

    logic        rdy_s, rv_s, err_s, busy_s, mdc_s, o_s, oe_s;
    logic [15:0] rdata_s;

    always_comb begin
        rdy_s   = sel ? if1.cmd_ready : if0.cmd_ready;
        rv_s    = sel ? if1.rsp_valid : if0.rsp_valid;
        err_s   = sel ? if1.rsp_err   : if0.rsp_err;
        rdata_s = sel ? if1.rsp_rdata : if0.rsp_rdata;
        busy_s  = sel ? busy1 : busy0;
        mdc_s   = sel ? mdc1  : mdc0;
        o_s     = sel ? o1    : o0;
        oe_s    = sel ? oe1   : oe0;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk($sformatf("%s_ready", tag), rdy_s, 1'b1);
        chk($sformatf("%s_busy", tag), busy_s, 1'b0);
        chk($sformatf("%s_rsp_valid", tag), rv_s, 1'b0);
        chk($sformatf("%s_mdc", tag), mdc_s, 1'b0);
        chk($sformatf("%s_mdio_o", tag), o_s, 1'b1);
        chk($sformatf("%s_mdio_oe", tag), oe_s, 1'b0);
    endtask

    // Called just after a negedge; the command is presented for the following posedge.
    // The frame is predicted slot by slot from the clause 22 layout and the MDC timing rule.
    task automatic run_cmd(input int d, input string tag, input logic w, input logic [4:0] r,
                           input logic [15:0] wd, input logic present, input logic [15:0] pdata,
                           input logic hold, input int abort_slot);
        logic [63:0] fr;
        logic [17:0] resp;
        int   mdc_bad, o_bad, oe_bad, hs_bad, last, slot, ph, rv_seen;
        logic exp_mdc, exp_oe, aborted;
        fr      = {32'hFFFF_FFFF, 2'b01, (w ? 2'b01 : 2'b10), 5'd1, r, 2'b10, (w ? wd : 16'h0000)};
        resp    = present ? {2'b10, pdata} : 18'h3FFFF;
        mdc_bad = 0; o_bad = 0; oe_bad = 0; hs_bad = 0; aborted = 1'b0;
        last    = 130 * d;
        chk($sformatf("%s_accept_ready", tag), rdy_s, 1'b1);
        cv = 1'b1; cw = w; creg = r; cwd = wd;
        for (int t = 1; t <= last; t++) begin
            @(negedge clk);
            if (!hold) cv = 1'b0;
            slot = (t - 1) / (2 * d);
            ph   = (t - 1) % (2 * d);
            if (slot < 64) begin
                exp_mdc = (ph >= d);
                exp_oe  = w || (slot < 46);
            end else begin
                exp_mdc = 1'b0;
                exp_oe  = 1'b0;
            end
            if (mdc_s !== exp_mdc) mdc_bad++;
            if (oe_s !== exp_oe) oe_bad++;
            if (exp_oe && o_s !== fr[63 - slot]) o_bad++;
            if (slot >= 64 && o_s !== 1'b1) o_bad++;
            if (rv_s !== (t == last) || rdy_s !== (t == last) || busy_s !== (t != last)) hs_bad++;
            mdio_i = (!w && slot >= 46 && slot < 64) ? resp[63 - slot] : 1'b1;
            if (abort_slot >= 0 && t == abort_slot * 2 * d + 1) begin
                aborted = 1'b1;
                break;
            end
        end
        chk($sformatf("%s_mdc_bad", tag), mdc_bad, 0);
        chk($sformatf("%s_oe_bad", tag), oe_bad, 0);
        chk($sformatf("%s_mdio_o_bad", tag), o_bad, 0);
        chk($sformatf("%s_handshake_bad", tag), hs_bad, 0);
        if (aborted) begin
            rst = 1'b1;
            @(negedge clk);
            chk_idle($sformatf("%s_rst", tag));
            rst    = 1'b0;
            mdio_i = 1'b1;
            rv_seen = 0;
            for (int t = 0; t < last; t++) begin
                @(negedge clk);
                if (rv_s !== 1'b0 || mdc_s !== 1'b0) rv_seen++;
            end
            chk($sformatf("%s_quiet_after_rst", tag), rv_seen, 0);
        end else begin
            chk($sformatf("%s_rdata", tag), rdata_s, w ? 16'h0000 : (present ? pdata : 16'hFFFF));
            chk($sformatf("%s_err", tag), err_s, (!w && !present));
        end
    endtask

    initial begin
        logic prev_hold, w, present, hold;
        sel = 1'b0; cv = 1'b0; cw = 1'b0; creg = '0; cwd = '0; mdio_i = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk_idle($sformatf("reset%0d", s));
            chk($sformatf("reset%0d_rdata", s), rdata_s, 16'h0000);
            chk($sformatf("reset%0d_err", s), err_s, 1'b0);
        end
        sel = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        run_cmd(20, "wr_reg0", 1'b1, 5'd0, 16'h3100, 1'b0, 16'h0000, 1'b0, -1);
        @(negedge clk);
        run_cmd(20, "rd_reg1", 1'b0, 5'd1, 16'h0000, 1'b1, 16'h786D, 1'b0, -1);
        @(negedge clk);
        run_cmd(20, "rd_nophy", 1'b0, 5'd2, 16'h0000, 1'b0, 16'h0000, 1'b0, -1);
        @(negedge clk);
        run_cmd(20, "hold_a", 1'b1, 5'd4, 16'hA5A5, 1'b0, 16'h0000, 1'b1, -1);
        run_cmd(20, "hold_b", 1'b0, 5'd3, 16'h0000, 1'b1, 16'h1234, 1'b0, -1);
        @(negedge clk);
        run_cmd(20, "abort", 1'b1, 5'd0, 16'h8000, 1'b0, 16'h0000, 1'b0, 40);
        @(negedge clk);
        run_cmd(20, "post_abort", 1'b0, 5'd1, 16'h0000, 1'b1, 16'hBEEF, 1'b0, -1);

        sel = 1'b1;
        @(negedge clk);
        prev_hold = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (!prev_hold) @(negedge clk);
            w       = $urandom_range(0, 1) == 1;
            present = $urandom_range(0, 3) != 0;
            hold    = (i < 23) && ($urandom_range(0, 1) == 1);
            run_cmd(2, $sformatf("rand%0d", i), w, 5'($urandom_range(0, 31)),
                    16'($urandom), present, 16'($urandom), hold, -1);
            prev_hold = hold;
        end
        cv = 1'b0;
        @(negedge clk);
        chk_idle("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
